audio_mixer_nch: RTL and testbench



---
 rtl/cpc_audio_pkg.sv | 23 ++
 rtl/sd_dac_1bit.sv | 24 ++
 rtl/audio_mixer_nch.sv | 148 ++++++++++++++
 tb/tb_audio_mixer_nch.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpc_audio_pkg.sv
// Shared definitions for the CPC audio mixer: pan codes, mixer FSM states and
// the accumulator width rule.
package cpc_audio_pkg;

  localparam logic [1:0] PAN_LEFT   = 2'b00;
  localparam logic [1:0] PAN_CENTRE = 2'b01;
  localparam logic [1:0] PAN_RIGHT  = 2'b10;
  localparam logic [1:0] PAN_MUTE   = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    BEEP  = 2'd2,
    LATCH = 2'd3
  } mix_state_e;

  // Wide enough that a full sum of channels plus beeps only needs saturation
  // at the output stage.
  function automatic int acc_width(input int ow, input int cw);
    return ((ow > cw + 4) ? ow : cw + 4) + 1;
  endfunction

endpackage

// File: rtl/sd_dac_1bit.sv
// First-order sigma-delta DAC: the carry out of an OW-bit phase accumulator
// is the output bit, giving a ones density of pcm/2^OW.
module sd_dac_1bit #(
  parameter int OW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [OW-1:0] pcm,
  output logic          bit_out
);

  logic [OW:0] integ;

  always_ff @(posedge clk) begin
    if (rst) begin
      integ <= '0;
    end else begin
      integ <= {1'b0, integ[OW-1:0]} + {1'b0, pcm};
    end
  end

  assign bit_out = integ[OW];

endmodule

// File: rtl/audio_mixer_nch.sv
// N-channel panned stereo mixer with cassette beeps, output saturation and
// per-side 1-bit sigma-delta DACs. One channel is accumulated per clock.
module audio_mixer_nch
  import cpc_audio_pkg::*;
#(
  parameter int          NCH        = 3,
  parameter int          CW         = 14,
  parameter int          OW         = 16,
  parameter int unsigned BEEP_LEVEL = 32'h2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce_sample,
  input  logic [NCH*CW-1:0] ch_data,
  input  logic [NCH*2-1:0]  ch_pan,
  input  logic              mic,
  input  logic              ear,
  input  logic              mono,
  output logic              busy,
  output logic [OW-1:0]     pcm_left,
  output logic [OW-1:0]     pcm_right,
  output logic              pcm_valid,
  output logic              clip_left,
  output logic              clip_right,
  output logic              audio_out_left,
  output logic              audio_out_right
);

  localparam int AW = acc_width(OW, CW);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [AW-1:0] BEEP_AW = AW'(BEEP_LEVEL);

  // Handshake: ce_sample is a one-cycle request accepted only while busy is
  // low; pcm_valid pulses for one cycle when pcm_x and clip_x update.
  mix_state_e    state, state_next;
  logic [IW-1:0] idx;
  logic [AW-1:0] acc_left, acc_right;
  logic [CW-1:0] ch_sample;
  logic [1:0]    pan;
  logic [CW-1:0] add_left, add_right;
  logic [AW-1:0] beep_sum;

  function automatic logic [AW-1:0] sat_add(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[AW] ? {AW{1'b1}} : s[AW-1:0];
  endfunction

  assign ch_sample = ch_data[int'(idx)*CW +: CW];
  assign pan       = ch_pan[int'(idx)*2 +: 2];
  assign busy      = (state != IDLE);

  always_comb begin
    add_left  = '0;
    add_right = '0;
    if (pan != PAN_MUTE) begin
      if (mono) begin
        add_left  = ch_sample;
        add_right = ch_sample;
      end else begin
        case (pan)
          PAN_LEFT:   add_left = ch_sample;
          PAN_CENTRE: begin
            add_left  = ch_sample >> 1;
            add_right = ch_sample >> 1;
          end
          PAN_RIGHT:  add_right = ch_sample;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    beep_sum = sat_add(mic ? BEEP_AW : '0, ear ? BEEP_AW : '0);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ce_sample) state_next = ACCUM;
      ACCUM:   if (idx == IW'(NCH - 1)) state_next = BEEP;
      BEEP:    state_next = LATCH;
      LATCH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      acc_left   <= '0;
      acc_right  <= '0;
      pcm_left   <= '0;
      pcm_right  <= '0;
      pcm_valid  <= 1'b0;
      clip_left  <= 1'b0;
      clip_right <= 1'b0;
    end else begin
      state     <= state_next;
      pcm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (ce_sample) begin
            acc_left  <= '0;
            acc_right <= '0;
            idx       <= '0;
          end
        end
        ACCUM: begin
          acc_left  <= sat_add(acc_left,  {{(AW-CW){1'b0}}, add_left});
          acc_right <= sat_add(acc_right, {{(AW-CW){1'b0}}, add_right});
          idx       <= idx + IW'(1);
        end
        BEEP: begin
          acc_left  <= sat_add(acc_left,  beep_sum);
          acc_right <= sat_add(acc_right, beep_sum);
        end
        LATCH: begin
          // Any bit above the output width means the sum exceeds full scale.
          clip_left  <= |acc_left[AW-1:OW];
          clip_right <= |acc_right[AW-1:OW];
          pcm_left   <= (|acc_left[AW-1:OW])  ? {OW{1'b1}} : acc_left[OW-1:0];
          pcm_right  <= (|acc_right[AW-1:OW]) ? {OW{1'b1}} : acc_right[OW-1:0];
          pcm_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  sd_dac_1bit #(.OW(OW)) u_dac_left (
    .clk     (clk),
    .rst     (rst),
    .pcm     (pcm_left),
    .bit_out (audio_out_left)
  );

  sd_dac_1bit #(.OW(OW)) u_dac_right (
    .clk     (clk),
    .rst     (rst),
    .pcm     (pcm_right),
    .bit_out (audio_out_right)
  );

endmodule

// File: tb/tb_audio_mixer_nch.sv
// Directed bench for audio_mixer_nch (NCH=3, CW=8, OW=9, BEEP_LEVEL=64) with
// an expected-result queue filled at each accepted mix.
module tb_audio_mixer_nch;

  localparam int NCH  = 3;
  localparam int CW   = 8;
  localparam int OW   = 9;
  localparam int BEEP = 64;
  localparam int W    = 2*OW + 2;

  logic              clk;
  logic              rst;
  logic              ce_sample;
  logic [NCH*CW-1:0] ch_data;
  logic [NCH*2-1:0]  ch_pan;
  logic              mic;
  logic              ear;
  logic              mono;
  logic              busy;
  logic [OW-1:0]     pcm_left;
  logic [OW-1:0]     pcm_right;
  logic              pcm_valid;
  logic              clip_left;
  logic              clip_right;
  logic              audio_out_left;
  logic              audio_out_right;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  logic [W-1:0] exp_q[$];

  audio_mixer_nch #(
    .NCH(NCH), .CW(CW), .OW(OW), .BEEP_LEVEL(BEEP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ce_sample       (ce_sample),
    .ch_data         (ch_data),
    .ch_pan          (ch_pan),
    .mic             (mic),
    .ear             (ear),
    .mono            (mono),
    .busy            (busy),
    .pcm_left        (pcm_left),
    .pcm_right       (pcm_right),
    .pcm_valid       (pcm_valid),
    .clip_left       (clip_left),
    .clip_right      (clip_right),
    .audio_out_left  (audio_out_left),
    .audio_out_right (audio_out_right)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: {clip_left, clip_right, pcm_left, pcm_right}
  function automatic logic [W-1:0] model(input int a, pa, b, pb, c, pc,
                                         input logic m, e, mo);
    int v[3];
    int p[3];
    int l;
    int r;
    logic cl;
    logic cr;
    v = '{a, b, c};
    p = '{pa, pb, pc};
    l = 0;
    r = 0;
    for (int i = 0; i < 3; i++) begin
      if (p[i] == 3) continue;
      if (mo) begin
        l += v[i];
        r += v[i];
      end else if (p[i] == 0) begin
        l += v[i];
      end else if (p[i] == 1) begin
        l += v[i] / 2;
        r += v[i] / 2;
      end else begin
        r += v[i];
      end
    end
    l += BEEP * (int'(m) + int'(e));
    r += BEEP * (int'(m) + int'(e));
    cl = (l > 511);
    cr = (r > 511);
    if (cl) l = 511;
    if (cr) r = 511;
    return {cl, cr, OW'(l), OW'(r)};
  endfunction

  task automatic set_inputs(input int a, pa, b, pb, c, pc, input logic m, e, mo);
    ch_data = {8'(c), 8'(b), 8'(a)};
    ch_pan  = {2'(pc), 2'(pb), 2'(pa)};
    mic     = m;
    ear     = e;
    mono    = mo;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ce_sample = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", busy, 0);
    check("reset_valid", pcm_valid, 0);
    check("reset_pcm", {clip_left, clip_right, pcm_left, pcm_right}, 0);
    check("reset_audio", {audio_out_left, audio_out_right}, 0);
  endtask

  // Drives one mix and watches 12 cycles; k counts negedges after the accept edge.
  task automatic run_mix(input string tag, input int a, pa, b, pb, c, pc,
                         input logic m, e, mo, input bit retrigger);
    logic [W-1:0] exp;
    @(negedge clk);
    set_inputs(a, pa, b, pb, c, pc, m, e, mo);
    exp_q.push_back(model(a, pa, b, pb, c, pc, m, e, mo));
    ce_sample = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check({tag, "_busy"}, busy, (k <= 5) ? 1 : 0);
      check({tag, "_valid"}, pcm_valid, (k == 6) ? 1 : 0);
      if (pcm_valid) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_valid"}, 1, 0);
        end else begin
          exp = exp_q.pop_front();
          check({tag, "_result"}, {clip_left, clip_right, pcm_left, pcm_right}, exp);
        end
      end
      ce_sample = (retrigger && k == 2) ? 1'b1 : 1'b0;
    end
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    ce_sample = 1'b0;
    set_inputs(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    do_reset();

    run_mix("mix",  100, 0, 50, 1, 20, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    run_mix("sat",  255, 0, 255, 0, 255, 0, 1'b1, 1'b1, 1'b0, 1'b0);
    run_mix("drop", 7, 1, 9, 2, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    run_mix("mono", 10, 0, 20, 2, 30, 3, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) begin
      run_mix("rand",
              $urandom_range(0, 255), $urandom_range(0, 3),
              $urandom_range(0, 255), $urandom_range(0, 3),
              $urandom_range(0, 255), $urandom_range(0, 3),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0);
    end
    run_mix("mono_last", 10, 0, 20, 2, 30, 3, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset during a mix: reset sampled on the third edge after accept.
    @(negedge clk);
    set_inputs(100, 0, 100, 0, 100, 2, 1'b1, 1'b0, 1'b0);
    ce_sample = 1'b1;
    @(negedge clk);
    ce_sample = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", pcm_valid, 0);
    check("abort_pcm", {pcm_left, pcm_right}, 0);
    check("abort_audio", {audio_out_left, audio_out_right}, 0);
    begin
      int valid_seen;
      valid_seen = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (pcm_valid) valid_seen++;
      end
      check("abort_no_valid", valid_seen, 0);
    end

    // DAC density: left at half scale, right at zero.
    do_reset();
    begin
      int ones_l;
      int ones_r;
      ones_l = 0;
      ones_r = 0;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        ones_l += int'(audio_out_left);
        ones_r += int'(audio_out_right);
      end
      check("dac_zero_left", ones_l, 0);
      check("dac_zero_right", ones_r, 0);
    end
    run_mix("dac_mix", 200, 0, 56, 0, 0, 3, 1'b0, 1'b0, 1'b0, 1'b0);
    begin
      int ones_l;
      int ones_r;
      int alt_bad;
      logic prev;
      ones_l  = 0;
      ones_r  = 0;
      alt_bad = 0;
      prev    = 1'b0;
      for (int k = 0; k < 512; k++) begin
        @(negedge clk);
        if (k > 0 && audio_out_left == prev) alt_bad++;
        prev = audio_out_left;
        ones_l += int'(audio_out_left);
        ones_r += int'(audio_out_right);
      end
      check("dac_half_ones", ones_l, 256);
      check("dac_half_alternate", alt_bad, 0);
      check("dac_right_zero", ones_r, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
